// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared types, widths and word packing for the DAC channel scheduler.
//   state_e   - scheduler FSM states
//   WORD_W    - serial DAC word width {A[1:0], RNG, D[7:0]}
//   DATA_W    - sample width per channel
//   ADDR_W    - DAC address width (also the channel index width)
//   pack_word - builds the serial word, MSB (A[1]) first on the wire
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD,
    GAP
  } state_e;

  localparam int unsigned WORD_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;

  function automatic logic [WORD_W-1:0] pack_word(input logic [ADDR_W-1:0] addr,
                                                  input logic              rng,
                                                  input logic [DATA_W-1:0] data);
    return {addr, rng, data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter for the DAC channel scheduler.
//   i_req        - per-channel request vector
//   i_ptr        - index of the last granted channel; search starts just after it
//   i_fixed_prio - when high, channel 0 wins outright whenever it requests and is
//                  excluded from the round-robin search over the other channels
//   o_gnt        - one-hot grant
//   o_idx        - binary index of the granted channel
//   o_valid      - a grant was made this cycle
module rr_arbiter
  import dac_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [ADDR_W-1:0] i_ptr,
  input  logic              i_fixed_prio,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [ADDR_W-1:0] o_idx,
  output logic              o_valid
);

  logic              w_found;
  logic [ADDR_W-1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;

    if (i_fixed_prio && i_req[0]) begin
      o_gnt[0] = 1'b1;
      w_found  = 1'b1;
    end

    // Walk the channels starting one past the pointer; the pointer itself comes last.
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      w_cand = ADDR_W'((32'(i_ptr) + k) % NUM_CH);
      if (!w_found && i_req[w_cand] && !(i_fixed_prio && (w_cand == '0))) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end

    o_valid = w_found;
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler: shares one 4-channel serial DAC between up to NUM_CH sample
// producers. Pending requests are granted round-robin, the 11-bit word
// {A[1:0], RNG, D[7:0]} is shifted out MSB first on a divided DAC clock (DAC samples on
// the falling edge), then LOAD is pulsed low to update the addressed output.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   req_i      - per-channel request, held with stable data until ack
//   data_i     - channel i sample at [8i+7:8i]
//   ack_o      - one-cycle pulse when a channel's data is captured
//   busy_o     - transaction in progress (state != IDLE)
//   dac_data_o - DAC serial data
//   dac_clk_o  - DAC serial clock
//   dac_load_o - DAC LOAD, active low
//   dac_ldac_o - tied low (DAC updates on LOAD)
//
// Build option: define DAC_SCHED_FIXED_PRIO_EN to give channel 0 absolute priority,
// with the remaining channels round-robin among themselves.
module dac_channel_scheduler
  import dac_sched_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter logic [3:0]  RNG_MASK    = 4'b0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [DATA_W*NUM_CH-1:0] data_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic                     busy_o,
  output logic                     dac_data_o,
  output logic                     dac_clk_o,
  output logic                     dac_load_o,
  output logic                     dac_ldac_o
);

`ifdef DAC_SCHED_FIXED_PRIO_EN
  localparam logic FixedPrio = 1'b1;
`else
  localparam logic FixedPrio = 1'b0;
`endif

  localparam int unsigned CntW = 16;
  // Counter values at which the DAC clock falls, a bit ends, and LOAD ends.
  localparam logic [CntW-1:0] CycFall  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CycLast  = CntW'(2 * CLK_DIV - 1);
  localparam logic [CntW-1:0] LoadLast = CntW'(LOAD_CYCLES - 1);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [WORD_W-1:0]   r_shift;
  logic [3:0]          r_bit;
  logic [CntW-1:0]     r_cnt;
  logic [NUM_CH-1:0]   r_ack;
  logic                r_busy;
  logic                r_data;
  logic                r_clk;
  logic                r_load;

  logic [NUM_CH-1:0]   w_gnt;
  logic [ADDR_W-1:0]   w_gnt_idx;
  logic                w_gnt_valid;
  logic [WORD_W-1:0]   w_word;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .i_req        (req_i),
    .i_ptr        (r_ptr),
    .i_fixed_prio (FixedPrio),
    .o_gnt        (w_gnt),
    .o_idx        (w_gnt_idx),
    .o_valid      (w_gnt_valid)
  );

  // Data is taken only at the grant edge; later changes on data_i are ignored.
  assign w_word = pack_word(w_gnt_idx, RNG_MASK[w_gnt_idx],
                            data_i[DATA_W*int'(w_gnt_idx) +: DATA_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= ADDR_W'(NUM_CH - 1);
      r_shift <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_data  <= 1'b0;
      r_clk   <= 1'b0;
      r_load  <= 1'b1;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_shift <= w_word;
            r_data  <= w_word[WORD_W-1];
            r_clk   <= 1'b1;
            r_bit   <= 4'(WORD_W - 1);
            r_cnt   <= '0;
            r_ack   <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
            // With fixed priority, channel 0 grants leave the rotation untouched.
            if (!FixedPrio || (w_gnt_idx != '0)) begin
              r_ptr <= w_gnt_idx;
            end
          end
        end

        SHIFT: begin
          if (r_cnt == CycLast) begin
            r_cnt <= '0;
            if (r_bit == '0) begin
              r_clk   <= 1'b0;
              r_load  <= 1'b0;
              r_state <= LOAD;
            end else begin
              r_bit   <= r_bit - 4'd1;
              r_shift <= r_shift << 1;
              r_data  <= r_shift[WORD_W-2];
              r_clk   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // Mid-bit falling edge: data has been stable for CLK_DIV cycles.
            if (r_cnt == CycFall) begin
              r_clk <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (r_cnt == LoadLast) begin
            r_cnt   <= '0;
            r_load  <= 1'b1;
            r_data  <= 1'b0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        GAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack_o      = r_ack;
  assign busy_o     = r_busy;
  assign dac_data_o = r_data;
  assign dac_clk_o  = r_clk;
  assign dac_load_o = r_load;
  assign dac_ldac_o = 1'b0;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Self-checking bench for dac_channel_scheduler: a transaction-level model predicts every
// output from the cycle offset since the last grant; directed scenarios add literal checks.
module tb_dac_channel_scheduler;

  localparam int NUM_CH      = 4;
  localparam int CLK_DIV     = 2;
  localparam int LOAD_CYCLES = 2;
  localparam logic [3:0] RNG_MASK = 4'b0000;
  localparam int SHIFT_LEN   = 22 * CLK_DIV;
  localparam int TX_LEN      = 22 * CLK_DIV + LOAD_CYCLES + 1;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  req_i  = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  ack_o;
  logic        busy_o, dac_data_o, dac_clk_o, dac_load_o, dac_ldac_o;

  always #5 clk = ~clk;

  dac_channel_scheduler #(
    .NUM_CH      (NUM_CH),
    .CLK_DIV     (CLK_DIV),
    .LOAD_CYCLES (LOAD_CYCLES),
    .RNG_MASK    (RNG_MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .dac_data_o (dac_data_o),
    .dac_clk_o  (dac_clk_o),
    .dac_load_o (dac_load_o),
    .dac_ldac_o (dac_ldac_o)
  );

  // ---------------- transaction model ----------------
  logic        m_active;
  int          m_k;
  int          m_g;
  logic [10:0] m_word;
  int          m_ptr;

  always @(posedge clk or posedge reset) begin : p_model
    int g;
    int c;
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_g      <= 0;
      m_word   <= '0;
      m_ptr    <= NUM_CH - 1;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k + 1 >= TX_LEN) m_active <= 1'b0;
    end else begin
      g = -1;
`ifdef DAC_SCHED_FIXED_PRIO_EN
      if (req_i[0]) g = 0;
`endif
      for (int s = 1; s <= NUM_CH; s++) begin
        c = (m_ptr + s) % NUM_CH;
`ifdef DAC_SCHED_FIXED_PRIO_EN
        if (g < 0 && c != 0 && req_i[c[1:0]]) g = c;
`else
        if (g < 0 && req_i[c[1:0]]) g = c;
`endif
      end
      if (g >= 0) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_g      <= g;
        m_word   <= {g[1:0], RNG_MASK[g[1:0]], data_i[8*g +: 8]};
`ifdef DAC_SCHED_FIXED_PRIO_EN
        if (g != 0) m_ptr <= g;
`else
        m_ptr <= g;
`endif
      end
    end
  end

  // ---------------- checking and monitoring (single process via tick) ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          busy_cyc = 0, ack_cyc = 0, load_low_cyc = 0;
  int          g_ch[$];
  int          g_cyc[$];
  logic [10:0] words[$];
  logic [10:0] cap_word = '0;
  int          cap_cnt  = 0;
  logic        prev_dclk = 1'b0;
  logic        prev_load = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [3:0]  e_ack;
    logic        in_shift, in_load;
    logic [10:0] tw;
    @(negedge clk);
    cyc++;
    in_shift = m_active && (m_k < SHIFT_LEN);
    in_load  = m_active && (m_k >= SHIFT_LEN) && (m_k < SHIFT_LEN + LOAD_CYCLES);
    e_ack    = (m_active && m_k == 0) ? (4'b0001 << m_g) : 4'b0000;
    tw       = m_word >> (10 - m_k / (2 * CLK_DIV));
    chk("ack", {28'd0, ack_o}, {28'd0, e_ack});
    chk("busy", {31'd0, busy_o}, {31'd0, m_active});
    chk("dac_load", {31'd0, dac_load_o}, {31'd0, !in_load});
    chk("dac_ldac", {31'd0, dac_ldac_o}, 32'd0);
    chk("dac_clk", {31'd0, dac_clk_o},
        {31'd0, in_shift && ((m_k % (2 * CLK_DIV)) < CLK_DIV)});
    if (!in_load) chk("dac_data", {31'd0, dac_data_o}, {31'd0, in_shift ? tw[0] : 1'b0});

    if (busy_o) busy_cyc++;
    if (ack_o != '0) ack_cyc++;
    if (!dac_load_o) load_low_cyc++;
    if (reset) begin
      cap_word  = '0;
      cap_cnt   = 0;
      prev_dclk = 1'b0;
      prev_load = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ack_o[i]) begin
          g_ch.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (prev_dclk && !dac_clk_o) begin
        cap_word = {cap_word[9:0], dac_data_o};
        cap_cnt++;
      end
      if (prev_load && !dac_load_o) begin
        chk("bits_per_word", cap_cnt, 11);
        words.push_back(cap_word);
        cap_word = '0;
        cap_cnt  = 0;
      end
      prev_dclk = dac_clk_o;
      prev_load = dac_load_o;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int limit);
    int t = 0;
    while (g_ch.size() < n && t < limit) begin
      tick();
      t++;
    end
    chk("grant_timeout", {31'd0, g_ch.size() >= n}, 32'd1);
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    data_i[8*ch +: 8] = v;
  endtask

  int b0, a0, l0, gi, wi, w0;

  initial begin
    // T1: reset then idle with no requests
    idle(3);
    reset = 1'b0;
    idle(30);
    chk("idle_busy_cycles", busy_cyc, 0);
    chk("idle_ack_cycles", ack_cyc, 0);
    chk("idle_load_low", load_low_cyc, 0);

    // T2: single request, ch2 = 0xA5
    b0 = busy_cyc; a0 = ack_cyc; l0 = load_low_cyc; gi = g_ch.size(); wi = words.size();
    set_data(2, 8'hA5);
    req_i = 4'b0100;
    wait_grants(gi + 1, 10);
    req_i = 4'b0000;
    idle(60);
    chk("t2_grant_ch", g_ch[gi], 2);
    chk("t2_ack_width", ack_cyc - a0, 1);
    chk("t2_busy_cycles", busy_cyc - b0, 47);
    chk("t2_load_low", load_low_cyc - l0, 2);
    chk("t2_word_count", words.size() - wi, 1);
    chk("t2_word", {21'd0, words[wi]}, 32'h4A5);

    // T3: all four held, after reset the order is 0,1,2,3,0
    do_reset(2);
    gi = g_ch.size(); wi = words.size();
    data_i = 32'h44332211;
    req_i  = 4'b1111;
    wait_grants(gi + 5, 300);
    req_i = 4'b0000;
    idle(60);
    chk("t3_ch0", g_ch[gi], 0);
    chk("t3_ch1", g_ch[gi+1], 1);
    chk("t3_ch2", g_ch[gi+2], 2);
    chk("t3_ch3", g_ch[gi+3], 3);
    chk("t3_ch0_again", g_ch[gi+4], 0);
    for (int i = 1; i < 5; i++) chk("t3_spacing", g_cyc[gi+i] - g_cyc[gi+i-1], 48);
    chk("t3_w0", {21'd0, words[wi]}, 32'h011);
    chk("t3_w1", {21'd0, words[wi+1]}, 32'h222);
    chk("t3_w2", {21'd0, words[wi+2]}, 32'h433);
    chk("t3_w3", {21'd0, words[wi+3]}, 32'h644);
    chk("t3_w4", {21'd0, words[wi+4]}, 32'h011);

    // T4: ch3 pending during a ch1 transaction; its data changes before the grant
    gi = g_ch.size(); wi = words.size();
    set_data(1, 8'h5A);
    req_i = 4'b0010;
    wait_grants(gi + 1, 10);
    set_data(3, 8'h0F);
    req_i = 4'b1000;
    idle(20);
    set_data(3, 8'hC3);
    wait_grants(gi + 2, 100);
    req_i = 4'b0000;
    idle(60);
    chk("t4_first", g_ch[gi], 1);
    chk("t4_second", g_ch[gi+1], 3);
    chk("t4_spacing", g_cyc[gi+1] - g_cyc[gi], 48);
    chk("t4_w_ch1", {21'd0, words[wi]}, 32'h25A);
    chk("t4_w_ch3", {21'd0, words[wi+1]}, 32'h6C3);

    // T5: reset at bit 5 of a ch2 shift; ch1 and ch3 pending -> ch1 first after reset
    gi = g_ch.size();
    set_data(2, 8'h99);
    set_data(1, 8'h3C);
    set_data(3, 8'h81);
    req_i = 4'b0100;
    wait_grants(gi + 1, 10);
    req_i = 4'b1010;
    idle(21);
    w0 = words.size();
    reset = 1'b1;
    #1;
    chk("t5_async_load", {31'd0, dac_load_o}, 32'd1);
    chk("t5_async_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_async_clk", {31'd0, dac_clk_o}, 32'd0);
    chk("t5_async_data", {31'd0, dac_data_o}, 32'd0);
    idle(2);
    reset = 1'b0;
    wait_grants(gi + 2, 10);
    req_i = 4'b0000;
    idle(60);
    chk("t5_pre_ch", g_ch[gi], 2);
    chk("t5_post_ch", g_ch[gi+1], 1);
    chk("t5_loads", words.size() - w0, 1);
    chk("t5_word", {21'd0, words[w0]}, 32'h23C);

    // T6: 1110 held, then ch0 raised: fixed priority picks ch0, round-robin picks ch2
    do_reset(2);
    gi = g_ch.size();
    data_i = 32'hD4C3B2A1;
    req_i  = 4'b1110;
    wait_grants(gi + 1, 10);
    req_i = 4'b1111;
    wait_grants(gi + 2, 100);
    req_i = 4'b0000;
    idle(60);
    chk("t6_first", g_ch[gi], 1);
`ifdef DAC_SCHED_FIXED_PRIO_EN
    chk("t6_second", g_ch[gi+1], 0);
`else
    chk("t6_second", g_ch[gi+1], 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
